// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache types: build configuration, refill slot layout and event flags.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned nr_fetch_ports;
    int unsigned fetch_aw;
    int unsigned line_width;
    int unsigned pending_count;
  } config_t;

  localparam config_t DefaultCfg = '{
    nr_fetch_ports: 4,
    fetch_aw:       32,
    line_width:     128,
    pending_count:  4
  };

  // Width of an index over n items; never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefPorts     = DefaultCfg.nr_fetch_ports;
  localparam int unsigned DefLineAlign = $clog2(DefaultCfg.line_width / 8);
  localparam int unsigned DefTagW      = DefaultCfg.fetch_aw - DefLineAlign;

  typedef struct packed {
    logic                valid;
    logic [DefTagW-1:0]  tag;
    logic [DefPorts-1:0] mask;
  } refill_slot_t;

  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
    logic l0_refill_merge;
  } icache_events_t;

endpackage

// File: rtl/snitch_icache_refill_table.sv
// Outstanding-refill slot array: tag match, lowest-free search, merge, allocate and free on response.
module snitch_icache_refill_table
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter int unsigned PENDING_COUNT  = 4,
  parameter int unsigned TAG_W          = 28,
  parameter int unsigned PENDING_IW     = clog2_min1(PENDING_COUNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [TAG_W-1:0]          lookup_tag_i,
  output logic                      match_hit_o,
  output logic [PENDING_IW-1:0]     match_idx_o,
  output logic                      free_avail_o,
  output logic [PENDING_IW-1:0]     free_idx_o,
  input  logic                      merge_en_i,
  input  logic [PENDING_IW-1:0]     merge_idx_i,
  input  logic [NR_FETCH_PORTS-1:0] merge_mask_i,
  input  logic                      alloc_en_i,
  input  logic [PENDING_IW-1:0]     alloc_idx_i,
  input  logic [TAG_W-1:0]          alloc_tag_i,
  input  logic [NR_FETCH_PORTS-1:0] alloc_mask_i,
  input  logic                      rsp_valid_i,
  input  logic [PENDING_IW-1:0]     rsp_id_i,
  output logic                      rsp_hit_o,
  output logic [TAG_W-1:0]          rsp_tag_o,
  output logic [NR_FETCH_PORTS-1:0] rsp_mask_o,
  output logic                      busy_o
);

  typedef struct packed {
    logic                      valid;
    logic [TAG_W-1:0]          tag;
    logic [NR_FETCH_PORTS-1:0] mask;
  } slot_t;

  slot_t slot_q [PENDING_COUNT];
  slot_t slot_d [PENDING_COUNT];
  logic [PENDING_COUNT-1:0] freeing;

  always_comb begin
    slot_d       = slot_q;
    freeing      = '0;
    match_hit_o  = 1'b0;
    match_idx_o  = '0;
    free_avail_o = 1'b0;
    free_idx_o   = '0;
    busy_o       = 1'b0;
    rsp_hit_o    = 1'b0;
    rsp_tag_o    = '0;
    rsp_mask_o   = '0;
    for (int i = 0; i < PENDING_COUNT; i++) begin
      freeing[i] = rsp_valid_i && (rsp_id_i == PENDING_IW'(i)) && slot_q[i].valid;
      busy_o     = busy_o | slot_q[i].valid;
      if (freeing[i]) begin
        rsp_hit_o       = 1'b1;
        rsp_tag_o       = slot_q[i].tag;
        rsp_mask_o      = slot_q[i].mask;
        slot_d[i].valid = 1'b0;
      end
      // A slot being freed this cycle is invisible to lookups; its free state only shows next cycle.
      if (!match_hit_o && slot_q[i].valid && !freeing[i] && (slot_q[i].tag == lookup_tag_i)) begin
        match_hit_o = 1'b1;
        match_idx_o = PENDING_IW'(i);
      end
      if (!free_avail_o && !slot_q[i].valid) begin
        free_avail_o = 1'b1;
        free_idx_o   = PENDING_IW'(i);
      end
    end
    for (int i = 0; i < PENDING_COUNT; i++) begin
      if (merge_en_i && (merge_idx_i == PENDING_IW'(i))) begin
        slot_d[i].mask = slot_q[i].mask | merge_mask_i;
      end
      if (alloc_en_i && (alloc_idx_i == PENDING_IW'(i))) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].tag   = alloc_tag_i;
        slot_d[i].mask  = alloc_mask_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PENDING_COUNT; i++) begin
        slot_q[i].valid <= 1'b0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && rsp_valid_i) begin
      assert (rsp_hit_o)
        else $warning("refill response id %0d targets an idle slot and is dropped", rsp_id_i);
    end
  end

endmodule

// File: rtl/snitch_icache_refill_sched.sv
// Round-robin scheduler of L0 miss refills onto the shared L1 port, with miss merging and line broadcast.
module snitch_icache_refill_sched
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter int unsigned FETCH_AW       = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned PENDING_COUNT  = 4,
  parameter int unsigned PENDING_IW     = clog2_min1(PENDING_COUNT)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NR_FETCH_PORTS*FETCH_AW-1:0] in_addr_i,
  input  logic [NR_FETCH_PORTS-1:0]          in_valid_i,
  output logic [NR_FETCH_PORTS-1:0]          in_ready_o,
  output logic [FETCH_AW-1:0]                out_addr_o,
  output logic [PENDING_IW-1:0]              out_id_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  input  logic [LINE_WIDTH-1:0]              rsp_data_i,
  input  logic [PENDING_IW-1:0]              rsp_id_i,
  input  logic                               rsp_valid_i,
  output logic [LINE_WIDTH-1:0]              port_data_o,
  output logic [FETCH_AW-1:0]                port_addr_o,
  output logic [NR_FETCH_PORTS-1:0]          port_valid_o,
  output logic                               busy_o,
  output logic                               stall_o
);

  localparam int unsigned LINE_ALIGN = $clog2(LINE_WIDTH / 8);
  localparam int unsigned TAG_W      = FETCH_AW - LINE_ALIGN;
  localparam int unsigned PTR_W      = clog2_min1(NR_FETCH_PORTS);

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      lock_q, lock_d;
  logic [PTR_W-1:0]          lock_port_q, lock_port_d;
  logic [PENDING_IW-1:0]     lock_id_q, lock_id_d;
  logic [NR_FETCH_PORTS-1:0] port_valid_q, port_valid_d;
  logic [LINE_WIDTH-1:0]     port_data_q, port_data_d;
  logic [FETCH_AW-1:0]       port_addr_q, port_addr_d;

  logic                      use_lock, gnt_valid, gnt_ready, issue;
  logic [PTR_W-1:0]          gnt_idx, cand;
  logic [NR_FETCH_PORTS-1:0] gnt_onehot;
  logic [TAG_W-1:0]          gnt_tag;
  logic [PENDING_IW-1:0]     issue_id;

  logic                      match_hit, free_avail, rsp_hit, tbl_busy;
  logic [PENDING_IW-1:0]     match_idx, free_idx;
  logic [TAG_W-1:0]          rsp_tag;
  logic [NR_FETCH_PORTS-1:0] rsp_mask;

  logic [NR_FETCH_PORTS-1:0] unused_offset_bits;

  // The byte offset inside a line never influences scheduling.
  for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : g_offset
    assign unused_offset_bits[p] = ^in_addr_i[p*FETCH_AW +: LINE_ALIGN];
  end

  // An issue stalled by L1 keeps its port and slot ID until it is accepted or withdrawn.
  always_comb begin
    use_lock  = lock_q && in_valid_i[lock_port_q];
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (use_lock) begin
      gnt_valid = 1'b1;
      gnt_idx   = lock_port_q;
    end else begin
      for (int i = 0; i < NR_FETCH_PORTS; i++) begin
        cand = PTR_W'((int'(ptr_q) + i) % NR_FETCH_PORTS);
        if (!gnt_valid && in_valid_i[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    gnt_tag    = '0;
    gnt_onehot = '0;
    for (int p = 0; p < NR_FETCH_PORTS; p++) begin
      if (gnt_idx == PTR_W'(p)) begin
        gnt_tag       = in_addr_i[p*FETCH_AW + LINE_ALIGN +: TAG_W];
        gnt_onehot[p] = 1'b1;
      end
    end
  end

  always_comb begin
    issue       = gnt_valid && !match_hit && free_avail;
    issue_id    = use_lock ? lock_id_q : free_idx;
    gnt_ready   = gnt_valid && (match_hit || (issue && out_ready_i));
    in_ready_o  = gnt_ready ? gnt_onehot : '0;
    stall_o     = gnt_valid && !gnt_ready;
    out_valid_o = issue;
    out_id_o    = issue_id;
    out_addr_o  = {gnt_tag, {LINE_ALIGN{1'b0}}};

    ptr_d = ptr_q;
    if (gnt_ready) begin
      ptr_d = (gnt_idx == PTR_W'(NR_FETCH_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
    lock_d      = issue && !out_ready_i;
    lock_port_d = gnt_idx;
    lock_id_d   = issue_id;

    port_valid_d = rsp_hit ? rsp_mask : '0;
    port_data_d  = rsp_hit ? rsp_data_i : port_data_q;
    port_addr_d  = rsp_hit ? {rsp_tag, {LINE_ALIGN{1'b0}}} : port_addr_q;
  end

  snitch_icache_refill_table #(
    .NR_FETCH_PORTS (NR_FETCH_PORTS),
    .PENDING_COUNT  (PENDING_COUNT),
    .TAG_W          (TAG_W),
    .PENDING_IW     (PENDING_IW)
  ) i_table (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lookup_tag_i (gnt_tag),
    .match_hit_o  (match_hit),
    .match_idx_o  (match_idx),
    .free_avail_o (free_avail),
    .free_idx_o   (free_idx),
    .merge_en_i   (gnt_valid && match_hit),
    .merge_idx_i  (match_idx),
    .merge_mask_i (gnt_onehot),
    .alloc_en_i   (issue && out_ready_i),
    .alloc_idx_i  (issue_id),
    .alloc_tag_i  (gnt_tag),
    .alloc_mask_i (gnt_onehot),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_id_i     (rsp_id_i),
    .rsp_hit_o    (rsp_hit),
    .rsp_tag_o    (rsp_tag),
    .rsp_mask_o   (rsp_mask),
    .busy_o       (tbl_busy)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      lock_q       <= 1'b0;
      lock_port_q  <= '0;
      lock_id_q    <= '0;
      port_valid_q <= '0;
      port_data_q  <= '0;
      port_addr_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      lock_q       <= lock_d;
      lock_port_q  <= lock_port_d;
      lock_id_q    <= lock_id_d;
      port_valid_q <= port_valid_d;
      port_data_q  <= port_data_d;
      port_addr_q  <= port_addr_d;
    end
  end

  assign port_valid_o = port_valid_q;
  assign port_data_o  = port_data_q;
  assign port_addr_o  = port_addr_q;
  assign busy_o       = tbl_busy;

endmodule

// File: tb/tb_snitch_icache_refill_sched.sv
// Directed bench for the L0 refill scheduler: issue, merge, full table, round robin, free/lookup race, reset.
module tb_snitch_icache_refill_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_addr;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_addr;
  logic [1:0]   out_id;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_valid;
  logic [127:0] port_data;
  logic [31:0]  port_addr;
  logic [3:0]   port_valid;
  logic         busy;
  logic         stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snitch_icache_refill_sched dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_addr_i    (in_addr),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_addr_o   (out_addr),
    .out_id_o     (out_id),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .rsp_data_i   (rsp_data),
    .rsp_id_i     (rsp_id),
    .rsp_valid_i  (rsp_valid),
    .port_data_o  (port_data),
    .port_addr_o  (port_addr),
    .port_valid_o (port_valid),
    .busy_o       (busy),
    .stall_o      (stall)
  );

  task automatic set_port(input int p, input logic [31:0] a, input logic v);
    in_addr[p*32 +: 32] = a;
    in_valid[p]         = v;
  endtask

  task automatic respond(input logic [1:0] id, input logic [127:0] d);
    rsp_valid = 1'b1;
    rsp_id    = id;
    rsp_data  = d;
  endtask

  // Returns every slot 0..3 so the next scenario starts with an empty table.
  task automatic drain_all;
    for (int id = 0; id < 4; id++) begin
      @(negedge clk);
      respond(2'(id), 128'h0);
    end
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_addr = '0; in_valid = '0; out_ready = 1'b0;
    rsp_valid = 1'b0; rsp_id = '0; rsp_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (port_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_port_valid got %b want 0000", port_valid); end
    n_cmp++; if (port_data !== 128'h0) begin n_bad++; $display("FAIL rst_port_data got %h want 0", port_data); end
    n_cmp++; if (port_addr !== 32'h0) begin n_bad++; $display("FAIL rst_port_addr got %h want 0", port_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_in_ready got %b want 0000", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single_refill;
    logic [127:0] d = 128'hDEADBEEF_00112233_44556677_8899AABB;
    @(negedge clk);
    set_port(0, 32'h0000_1004, 1'b1); out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL t1_out_valid got %b want 1", out_valid); end
    n_cmp++; if (out_id !== 2'd0) begin n_bad++; $display("FAIL t1_out_id got %0d want 0", out_id); end
    n_cmp++; if (out_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL t1_out_addr got %h want 00001000", out_addr); end
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL t1_in_ready got %b want 0001", in_ready); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL t1_stall got %b want 0", stall); end
    @(negedge clk);
    set_port(0, 32'h0, 1'b0); respond(2'd0, d);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy got %b want 1", busy); end
    n_cmp++; if (port_valid !== 4'b0000) begin n_bad++; $display("FAIL t1_early_strobe got %b want 0000", port_valid); end
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    n_cmp++; if (port_valid !== 4'b0001) begin n_bad++; $display("FAIL t1_port_valid got %b want 0001", port_valid); end
    n_cmp++; if (port_data !== d) begin n_bad++; $display("FAIL t1_port_data got %h want %h", port_data, d); end
    n_cmp++; if (port_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL t1_port_addr got %h want 00001000", port_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_after got %b want 0", busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (port_valid !== 4'b0000) begin n_bad++; $display("FAIL t1_strobe_len got %b want 0000", port_valid); end
  endtask

  task automatic test_merge;
    logic [127:0] d = 128'h22222222_33333333_44444444_55555555;
    @(negedge clk);
    set_port(1, 32'h0000_2040, 1'b1);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL t2_issue got %b want 1", out_valid); end
    n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL t2_ready1 got %b want 0010", in_ready); end
    @(negedge clk);
    set_port(1, 32'h0, 1'b0); set_port(2, 32'h0000_2048, 1'b1);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t2_no_second_issue got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL t2_merge_ready got %b want 0100", in_ready); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL t2_stall got %b want 0", stall); end
    @(negedge clk);
    set_port(2, 32'h0, 1'b0); respond(2'd0, d);
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    n_cmp++; if (port_valid !== 4'b0110) begin n_bad++; $display("FAIL t2_port_valid got %b want 0110", port_valid); end
    n_cmp++; if (port_addr !== 32'h0000_2040) begin n_bad++; $display("FAIL t2_port_addr got %h want 00002040", port_addr); end
    n_cmp++; if (port_data !== d) begin n_bad++; $display("FAIL t2_port_data got %h want %h", port_data, d); end
  endtask

  task automatic test_full_table;
    logic [127:0] d = 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_port(3, 32'h0000_4000 + 32'(i * 16), 1'b1);
      #1;
      n_cmp++; if (out_id !== 2'(i)) begin n_bad++; $display("FAIL t3_id%0d got %0d want %0d", i, out_id, i); end
      n_cmp++; if (in_ready !== 4'b1000) begin n_bad++; $display("FAIL t3_ready%0d got %b want 1000", i, in_ready); end
    end
    @(negedge clk);
    set_port(3, 32'h0000_4040, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL t3_full_ready got %b want 0000", in_ready); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL t3_full_stall got %b want 1", stall); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t3_full_out_valid got %b want 0", out_valid); end
    @(negedge clk);
    respond(2'd2, d);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL t3_free_cycle_stall got %b want 1", stall); end
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL t3_reissue got %b want 1", out_valid); end
    n_cmp++; if (out_id !== 2'd2) begin n_bad++; $display("FAIL t3_reissue_id got %0d want 2", out_id); end
    n_cmp++; if (out_addr !== 32'h0000_4040) begin n_bad++; $display("FAIL t3_reissue_addr got %h want 00004040", out_addr); end
    n_cmp++; if (in_ready !== 4'b1000) begin n_bad++; $display("FAIL t3_reissue_ready got %b want 1000", in_ready); end
    n_cmp++; if (port_valid !== 4'b1000) begin n_bad++; $display("FAIL t3_port_valid got %b want 1000", port_valid); end
    n_cmp++; if (port_addr !== 32'h0000_4020) begin n_bad++; $display("FAIL t3_port_addr got %h want 00004020", port_addr); end
    @(negedge clk);
    set_port(3, 32'h0, 1'b0);
    drain_all();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t3_drained got %b want 0", busy); end
  endtask

  task automatic test_round_robin;
    logic [8:0] rdy    = 9'b1_1101_0101;
    logic [8:0] exp_ov = 9'b1_0111_1111;
    logic [3:0] exp_rdy [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    logic [1:0] exp_id  [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [127:0] d = 128'h44444444_44444444_44444444_44444444;
    @(negedge clk);
    for (int p = 0; p < 4; p++) set_port(p, 32'h0000_5000 + 32'(p * 256), 1'b1);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
          if (exp_rdy[c-1][p]) in_addr[p*32 +: 32] = in_addr[p*32 +: 32] + 32'h400;
        end
      end
      out_ready = rdy[c];
      if (c == 7) respond(2'd0, d); else rsp_valid = 1'b0;
      #1;
      n_cmp++; if (in_ready !== exp_rdy[c]) begin n_bad++; $display("FAIL t4_ready_c%0d got %b want %b", c, in_ready, exp_rdy[c]); end
      n_cmp++; if (out_valid !== exp_ov[c]) begin n_bad++; $display("FAIL t4_out_valid_c%0d got %b want %b", c, out_valid, exp_ov[c]); end
      if (exp_ov[c]) begin
        n_cmp++; if (out_id !== exp_id[c]) begin n_bad++; $display("FAIL t4_id_c%0d got %0d want %0d", c, out_id, exp_id[c]); end
      end
    end
    n_cmp++; if (out_addr !== 32'h0000_5400) begin n_bad++; $display("FAIL t4_wrap_addr got %h want 00005400", out_addr); end
    n_cmp++; if (port_valid !== 4'b0001) begin n_bad++; $display("FAIL t4_port_valid got %b want 0001", port_valid); end
    @(negedge clk);
    in_valid = '0; out_ready = 1'b1;
    drain_all();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t4_drained got %b want 0", busy); end
  endtask

  task automatic test_free_same_cycle;
    logic [127:0] d0 = 128'hA0A0A0A0_A0A0A0A0_A0A0A0A0_A0A0A0A0;
    logic [127:0] d1 = 128'hB1B1B1B1_B1B1B1B1_B1B1B1B1_B1B1B1B1;
    @(negedge clk);
    set_port(0, 32'h0000_3000, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL t5_first_ready got %b want 0001", in_ready); end
    @(negedge clk);
    set_port(0, 32'h0, 1'b0); set_port(3, 32'h0000_3000, 1'b1); respond(2'd0, d0);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL t5_new_issue got %b want 1", out_valid); end
    n_cmp++; if (out_id !== 2'd1) begin n_bad++; $display("FAIL t5_new_id got %0d want 1", out_id); end
    n_cmp++; if (in_ready !== 4'b1000) begin n_bad++; $display("FAIL t5_ready got %b want 1000", in_ready); end
    @(negedge clk);
    set_port(3, 32'h0, 1'b0); rsp_valid = 1'b0;
    #1;
    n_cmp++; if (port_valid !== 4'b0001) begin n_bad++; $display("FAIL t5_first_strobe got %b want 0001", port_valid); end
    n_cmp++; if (port_data !== d0) begin n_bad++; $display("FAIL t5_first_data got %h want %h", port_data, d0); end
    @(negedge clk);
    respond(2'd1, d1);
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    n_cmp++; if (port_valid !== 4'b1000) begin n_bad++; $display("FAIL t5_second_strobe got %b want 1000", port_valid); end
    n_cmp++; if (port_addr !== 32'h0000_3000) begin n_bad++; $display("FAIL t5_second_addr got %h want 00003000", port_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t5_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    set_port(0, 32'h0000_6000, 1'b1);
    #1;
    n_cmp++; if (out_id !== 2'd0) begin n_bad++; $display("FAIL t6_id0 got %0d want 0", out_id); end
    @(negedge clk);
    set_port(0, 32'h0, 1'b0); set_port(1, 32'h0000_6010, 1'b1);
    #1;
    n_cmp++; if (out_id !== 2'd1) begin n_bad++; $display("FAIL t6_id1 got %0d want 1", out_id); end
    @(negedge clk);
    set_port(1, 32'h0, 1'b0);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t6_busy_before got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; respond(2'd0, 128'h77777777_77777777_77777777_77777777);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t6_busy_after got %b want 0", busy); end
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    n_cmp++; if (port_valid !== 4'b0000) begin n_bad++; $display("FAIL t6_late_rsp got %b want 0000", port_valid); end
    n_cmp++; if (port_data !== 128'h0) begin n_bad++; $display("FAIL t6_late_data got %h want 0", port_data); end
    // Pointer was 2 before reset; after reset ports 1 and 2 contend and port 1 must win.
    @(negedge clk);
    set_port(1, 32'h0000_7000, 1'b1); set_port(2, 32'h0000_7100, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL t6_ptr_reset got %b want 0010", in_ready); end
    @(negedge clk);
    in_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_refill();
    test_merge();
    test_full_table();
    test_round_robin();
    test_free_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
